// File: rtl/instasm_loader_pkg.sv
// Shared definitions for the instruction assembler/loader.
// Holds instruction field widths, the fmt encodings, the FSM state
// encodings, the packed field bundle and the word-assembly function.
package instasm_loader_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned INDEX_W  = 26;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_ILL = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [SHAMT_W-1:0]  shamt;
        logic [FUNCT_W-1:0]  funct;
        logic [IMM_W-1:0]    imm;
        logic [INDEX_W-1:0]  instr_index;
    } fields_t;

    // Opcode always lands in bits 31:26; illegal formats yield zero.
    function automatic logic [WORD_W-1:0] assemble(input logic [1:0] fmt, input fields_t f);
        logic [WORD_W-1:0] word;
        word = '0;
        case (fmt_e'(fmt))
            FMT_R:   word = {f.opcode, f.rs, f.rt, f.rd, f.shamt, f.funct};
            FMT_I:   word = {f.opcode, f.rs, f.rt, f.imm};
            FMT_J:   word = {f.opcode, f.instr_index};
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instasm_loader_fifo.sv
// inst_fifo: DEPTH-entry, 32-bit synchronous FIFO for assembled words.
// Ports: clk, rst_n (async active-low), push/wdata (write side),
// pop/rdata (read side, rdata = head), full, empty.
// Push while full and pop while empty are ignored.
module inst_fifo
    import instasm_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic [WORD_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instasm_loader.sv
// instasm_loader: assembles R/I/J instruction fields into 32-bit words
// and writes them to consecutive IMEM addresses starting at base_addr.
// Ports: clk, rst_n (async active-low); start/base_addr/num_words open a
// session; in_valid/in_ready with fmt and field inputs deliver beats;
// imem_we/imem_ready/imem_addr/imem_wdata write words out;
// busy/done/fmt_err report status.
module instasm_loader
    import instasm_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [31:0]         base_addr,
    input  logic [CNT_W-1:0]    num_words,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          fmt,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [IMM_W-1:0]    imm,
    input  logic [INDEX_W-1:0]  instr_index,
    output logic                imem_we,
    input  logic                imem_ready,
    output logic [31:0]         imem_addr,
    output logic [WORD_W-1:0]   imem_wdata,
    output logic                busy,
    output logic                done,
    output logic                fmt_err
);

    state_e             state;
    state_e             state_next;
    logic [31:0]        base_r;
    logic [CNT_W-1:0]   num_r;
    logic [CNT_W-1:0]   acc_cnt;
    logic [CNT_W-1:0]   wr_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               beat;
    logic               push;
    logic               pop;
    logic               bad_beat;
    fields_t            fields;
    logic [WORD_W-1:0]  word;

    assign fields = '{opcode: opcode, rs: rs, rt: rt, rd: rd, shamt: shamt,
                      funct: funct, imm: imm, instr_index: instr_index};
    assign word   = assemble(fmt, fields);

    assign beat     = in_valid & in_ready;
    assign bad_beat = beat & (fmt_e'(fmt) == FMT_ILL);
    assign push     = beat & (fmt_e'(fmt) != FMT_ILL);
    assign pop      = imem_we & imem_ready;

    assign imem_addr = base_r + {14'b0, wr_cnt, 2'b00};

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (imem_wdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_words == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                in_ready = ~fifo_full & (acc_cnt < num_r);
                imem_we  = ~fifo_empty;
                // Leave on the edge that completes the final write.
                if (pop && (wr_cnt + 16'd1 == num_r)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r  <= '0;
            num_r   <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            fmt_err <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            base_r  <= base_addr;
            num_r   <= num_words;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            fmt_err <= 1'b0;
        end else begin
            if (push)     acc_cnt <= acc_cnt + 1'b1;
            if (pop)      wr_cnt  <= wr_cnt + 1'b1;
            if (bad_beat) fmt_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instasm_loader.sv
// Self-checking bench for instasm_loader (DEPTH 4): table of assembly
// vectors plus directed multi-cycle sequences.
module tb_instasm_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = '0;
    logic [5:0]  opcode = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] instr_index = '0;
    logic        imem_we;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy, done, fmt_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    instasm_loader #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .instr_index(instr_index),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    // Record each write that will complete on the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (rst_n && imem_we && imem_ready) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_fields(input vec_t v);
        fmt = v.fmt; opcode = v.op; rs = v.rs; rt = v.rt; rd = v.rd;
        shamt = v.sh; funct = v.fn; imm = v.imm; instr_index = v.idx;
    endtask

    task automatic set_i(input logic [15:0] val);
        fmt = 2'b01; opcode = 6'h08; rs = 5'd1; rt = 5'd2; imm = val;
    endtask

    task automatic set_j(input logic [25:0] val);
        fmt = 2'b10; opcode = 6'h02; instr_index = val;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1; base_addr = b; num_words = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic new_session(input logic [31:0] b, input logic [15:0] n);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start(b, n);
    endtask

    // Offer one beat (fields already set) until it transfers.
    task automatic send_beat(input string name);
        int g;
        @(negedge clk);
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            errors++;
            $display("FAIL %s: in_ready timeout got 0 expected 1", name);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input string name, input int n);
        int g;
        g = 0;
        while (wr_addr_q.size() < n && g < 200) begin
            @(negedge clk);
            #2;
            g++;
        end
        if (wr_addr_q.size() < n) begin
            errors++;
            $display("FAIL %s: write timeout got %0d expected %0d", name, wr_addr_q.size(), n);
        end
    endtask

    task automatic check_write(input string name, input int k, input logic [31:0] a, input logic [31:0] d);
        if (wr_addr_q.size() > k) check(name, {wr_addr_q[k], wr_data_q[k]}, {a, d});
        else check(name, 64'h0, {a, d});
    endtask

    initial begin
        int acc;
        logic rdy;

        vecs[0] = '{2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'h0, 32'h0022_1820};
        vecs[1] = '{2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0, 32'h2022_0005};
        vecs[2] = '{2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000100, 32'h0800_0100};
        vecs[3] = '{2'b00, 6'h3F, 5'h1F, 5'h00, 5'h1F, 5'h00, 6'h2A, 16'hABCD, 26'h1234567, 32'hFFE0_F82A};
        vecs[4] = '{2'b01, 6'h23, 5'h1D, 5'h08, 5'h1F, 5'h1F, 6'h3F, 16'hFFFC, 26'h3FFFFFF, 32'h8FA8_FFFC};
        vecs[5] = '{2'b10, 6'h03, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h0FFF_FFFF};

        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, fmt_err, in_ready, imem_we}, 5'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {busy, done, in_ready, imem_we}, 4'b0);

        // Assembly table: one single-word session per vector.
        imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            new_session(32'h1000 + 32'(i) * 32'h10, 16'd1);
            set_fields(vecs[i]);
            send_beat($sformatf("vec%0d_beat", i));
            wait_writes($sformatf("vec%0d_wr", i), 1);
            check_write($sformatf("vec%0d_word", i), 0, 32'h1000 + 32'(i) * 32'h10, vecs[i].exp);
            @(negedge clk);
            check($sformatf("vec%0d_done", i), {busy, done}, 2'b01);
            pulse_start(32'h0, 16'd0);
            check($sformatf("vec%0d_idle", i), {busy, done}, 2'b00);
        end

        // Two-word I/J session.
        new_session(32'h0000_3000, 16'd2);
        check("s33_busy", busy, 1'b1);
        set_i(16'h0005);
        send_beat("s33_beat0");
        set_j(26'h0000100);
        send_beat("s33_beat1");
        wait_writes("s33_wr", 2);
        check_write("s33_w0", 0, 32'h3000, 32'h2022_0005);
        check_write("s33_w1", 1, 32'h3004, 32'h0800_0100);
        @(negedge clk);
        check("s33_done", {busy, done}, 2'b01);
        check("s33_count", wr_addr_q.size(), 2);
        pulse_start(32'h0, 16'd0);

        // Backpressure: IMEM stalled, buffer fills at 4.
        imem_ready = 1'b0;
        new_session(32'h0000_4000, 16'd6);
        acc = 0;
        set_i(16'd0);
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) acc++;
            set_i(16'(acc));
        end
        check("s35_accepted", acc, 4);
        check("s35_in_ready_low", in_ready, 1'b0);
        check("s35_hold", {imem_we, imem_addr, imem_wdata}, {1'b1, 32'h4000, 32'h2022_0000});
        imem_ready = 1'b1;
        for (int c = 0; c < 50 && acc < 6; c++) begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) acc++;
            set_i(16'(acc));
        end
        in_valid = 1'b0;
        wait_writes("s35_wr", 6);
        for (int k = 0; k < 6; k++) begin
            check_write($sformatf("s35_w%0d", k), k, 32'h4000 + 32'(k) * 4, 32'h2022_0000 + 32'(k));
        end
        @(negedge clk);
        check("s35_done", {done, wr_addr_q.size() == 6}, 2'b11);
        pulse_start(32'h0, 16'd0);

        // Illegal beat mid-session; start while running is ignored.
        new_session(32'h0000_5000, 16'd2);
        set_i(16'h0001);
        send_beat("s36_beat0");
        check("s36_no_err_yet", fmt_err, 1'b0);
        pulse_start(32'h9999_0000, 16'd7);
        fmt = 2'b11; imm = 16'h7777;
        send_beat("s36_bad");
        check("s36_fmt_err", fmt_err, 1'b1);
        set_i(16'h0002);
        send_beat("s36_beat1");
        wait_writes("s36_wr", 2);
        check_write("s36_w0", 0, 32'h5000, 32'h2022_0001);
        check_write("s36_w1", 1, 32'h5004, 32'h2022_0002);
        repeat (3) @(negedge clk);
        check("s36_done_count", {done, fmt_err, 32'(wr_addr_q.size())}, {1'b1, 1'b1, 32'd2});
        pulse_start(32'h0, 16'd0);

        // Address wrap.
        new_session(32'hFFFF_FFFC, 16'd2);
        check("s37_err_cleared", fmt_err, 1'b0);
        set_j(26'h1);
        send_beat("s37_beat0");
        set_j(26'h2);
        send_beat("s37_beat1");
        wait_writes("s37_wr", 2);
        check_write("s37_w0", 0, 32'hFFFF_FFFC, 32'h0800_0001);
        check_write("s37_w1", 1, 32'h0000_0000, 32'h0800_0002);
        @(negedge clk);
        pulse_start(32'h0, 16'd0);

        // Empty session goes straight to DONE.
        new_session(32'h0000_8000, 16'd0);
        check("s_empty_done", {busy, done, in_ready, imem_we}, 4'b0100);
        pulse_start(32'h0, 16'd0);
        check("s_empty_idle", {busy, done}, 2'b00);

        // Reset mid-session.
        new_session(32'h0000_6000, 16'd3);
        fmt = 2'b11;
        send_beat("s38_bad");
        set_i(16'h0011);
        send_beat("s38_beat0");
        wait_writes("s38_wr", 1);
        imem_ready = 1'b0;
        set_i(16'h0012);
        send_beat("s38_beat1");
        @(negedge clk);
        check("s38_pre_reset", {busy, fmt_err, imem_we}, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check("s38_reset_now", {busy, done, fmt_err, in_ready, imem_we, imem_addr, imem_wdata}, 69'h0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("s38_idle", {busy, done, imem_we}, 3'b000);
        new_session(32'h0000_7000, 16'd1);
        set_j(26'h0000100);
        send_beat("s38_fresh_beat");
        wait_writes("s38_fresh_wr", 1);
        check_write("s38_fresh_w0", 0, 32'h7000, 32'h0800_0100);
        @(negedge clk);
        check("s38_fresh_done", {done, fmt_err}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
